// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle M-extension sequencer: funct3 ops,
// FSM states and the operand width.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM only.
  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring shift-subtract divide iteration on unsigned magnitudes.
module muldiv_div_step
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Shifted remainder needs one extra bit; the difference always fits XLEN
  // because the incoming remainder is already below the divisor.
  assign rem_sh = {rem_i, quo_i[XLEN-1]};
  assign diff   = rem_sh - {1'b0, div_i};

  always_comb begin
    if (rem_sh >= {1'b0, div_i}) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV/REM sequencer: single-cycle registered multiply, 32-step
// shift-subtract divide with sign fix-up, busy stall and one-cycle valid strobe.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  import muldiv_pkg::*;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [XLEN-1:0] mag_a_q, mag_a_d;   // multiplicand, or dividend then quotient
  logic [XLEN-1:0] mag_b_q, mag_b_d;   // multiplier or divisor
  logic [XLEN-1:0] rem_q, rem_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [2*XLEN-1:0] prod_abs;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   step_rem;
  logic [XLEN-1:0]   step_quo;
  logic [XLEN-1:0]   fix_quo;
  logic [XLEN-1:0]   fix_rem;
  logic              in_sign_a;
  logic              in_sign_b;

  muldiv_div_step u_div_step (
    .rem_i (rem_q),
    .quo_i (mag_a_q),
    .div_i (mag_b_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign prod_abs  = {{XLEN{1'b0}}, mag_a_q} * {{XLEN{1'b0}}, mag_b_q};
  assign prod      = (sign_a_q ^ sign_b_q) ? -prod_abs : prod_abs;
  assign fix_quo   = (sign_a_q ^ sign_b_q) ? -mag_a_q : mag_a_q;
  assign fix_rem   = sign_a_q ? -rem_q : rem_q;
  assign in_sign_a = rs1_i[XLEN-1] & rs1_signed(op_i);
  assign in_sign_b = rs2_i[XLEN-1] & rs2_signed(op_i);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (flush_i) begin
      // Flush wins over a simultaneous start and never touches result_q.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (start_i) begin
            op_d     = op_i;
            sign_a_d = in_sign_a;
            sign_b_d = in_sign_b;
            mag_a_d  = in_sign_a ? -rs1_i : rs1_i;
            mag_b_d  = in_sign_b ? -rs2_i : rs2_i;
            rem_d    = '0;
            cnt_d    = '0;
            if (!op_i[2]) begin
              state_d = StMul;
            end else if (rs2_i == '0) begin
              result_d = op_i[1] ? rs1_i : {XLEN{1'b1}};
              state_d  = StDone;
            end else if (!op_i[0] && rs1_i == {1'b1, {(XLEN-1){1'b0}}} &&
                         rs2_i == {XLEN{1'b1}}) begin
              result_d = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state_d  = StDone;
            end else begin
              state_d = StDiv;
            end
          end
        end
        StMul: begin
          result_d = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = StDone;
        end
        StDiv: begin
          rem_d   = step_rem;
          mag_a_d = step_quo;
          if (cnt_q == 5'd31) begin
            cnt_d   = '0;
            state_d = StFix;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        StFix: begin
          result_d = op_q[1] ? fix_rem : fix_quo;
          state_d  = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= StIdle;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
  assign valid_o  = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, results, specials,
// flush, back-to-back and asynchronous reset.
module tb_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  muldiv_seq #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Starts an op in the current cycle (cycle 0) and observes until valid_o.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int vcyc, output int bfirst, output int bcnt,
                        output logic [31:0] res, output logic vafter);
    int cyc;
    vcyc = -1; bfirst = -1; bcnt = 0; res = 'x;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    step();
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 60) begin
      if (busy_o) begin
        bcnt++;
        if (bfirst < 0) bfirst = cyc;
      end
      if (valid_o) begin
        vcyc = cyc;
        res  = result_o;
        break;
      end
      step();
      cyc++;
    end
    step();
    vafter = valid_o;
  endtask

  task automatic test_reset();
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_o); end
    reset_i = 1'b1;
    step();
    n_cmp++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got busy %b valid %b want 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int vcyc, bfirst, bcnt;
    logic [31:0] res;
    logic vafter;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], vcyc, bfirst, bcnt, res, vafter);
      n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, exp[i]); end
      n_cmp++; if (vcyc != 2) begin n_fail++; $display("FAIL mul_valid_cycle[%0d]: got %0d want 2", i, vcyc); end
      n_cmp++; if (bfirst != 1 || bcnt != 1) begin
        n_fail++; $display("FAIL mul_busy[%0d]: got first %0d count %0d want 1 1", i, bfirst, bcnt);
      end
      n_cmp++; if (vafter !== 1'b0) begin n_fail++; $display("FAIL mul_valid_pulse[%0d]: got %b want 0", i, vafter); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int vcyc, bfirst, bcnt;
    logic [31:0] res;
    logic vafter;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], vcyc, bfirst, bcnt, res, vafter);
      n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL special_result[%0d]: got %h want %h", i, res, exp[i]); end
      n_cmp++; if (vcyc != 1) begin n_fail++; $display("FAIL special_valid_cycle[%0d]: got %0d want 1", i, vcyc); end
      n_cmp++; if (bcnt != 0) begin n_fail++; $display("FAIL special_busy[%0d]: got %0d busy cycles want 0", i, bcnt); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int vcyc, bfirst, bcnt;
    logic [31:0] res;
    logic vafter;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], vcyc, bfirst, bcnt, res, vafter);
      n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL div_result[%0d]: got %h want %h", i, res, exp[i]); end
      n_cmp++; if (vcyc != 34) begin n_fail++; $display("FAIL div_valid_cycle[%0d]: got %0d want 34", i, vcyc); end
      n_cmp++; if (bfirst != 1 || bcnt != 33) begin
        n_fail++; $display("FAIL div_busy[%0d]: got first %0d count %0d want 1 33", i, bfirst, bcnt);
      end
    end
  endtask

  // Expects result_o == 2 on entry (last op of test_div was REMU 100/7).
  task automatic test_flush();
    int vcyc, bfirst, bcnt;
    logic [31:0] res;
    logic vafter;
    logic seen_valid;
    seen_valid = 1'b0;
    start_i = 1'b1; op_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) begin
      seen_valid |= valid_o;
      step();
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy_o); end
    n_cmp++; if (seen_valid || valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got 1 want 0"); end
    n_cmp++; if (result_o !== 32'd2) begin n_fail++; $display("FAIL flush_result_held: got %h want 2", result_o); end
    run_op(3'b101, 32'd100, 32'd7, vcyc, bfirst, bcnt, res, vafter);
    n_cmp++; if (res !== 32'd14 || vcyc != 34) begin
      n_fail++; $display("FAIL flush_restart: got %h at cycle %0d want 14 at 34", res, vcyc);
    end
    // Start together with flush is dropped.
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd3;
    step();
    start_i = 1'b0; flush_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL start_flush_busy: got %b want 0", busy_o); end
    seen_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen_valid |= valid_o;
      step();
    end
    n_cmp++; if (seen_valid) begin n_fail++; $display("FAIL start_flush_valid: got 1 want 0"); end
    n_cmp++; if (result_o !== 32'd14) begin n_fail++; $display("FAIL start_flush_result: got %h want 14", result_o); end
  endtask

  task automatic test_back_to_back();
    int vcyc, bfirst, bcnt;
    logic [31:0] res;
    logic vafter;
    start_i = 1'b1; op_i = 3'b000; rs1_i = 32'd6; rs2_i = 32'd7;
    step();
    start_i = 1'b0;
    step();
    n_cmp++; if (valid_o !== 1'b1 || result_o !== 32'd42) begin
      n_fail++; $display("FAIL b2b_first: got valid %b result %h want 1 2a", valid_o, result_o);
    end
    run_op(3'b101, 32'd100, 32'd7, vcyc, bfirst, bcnt, res, vafter);
    n_cmp++; if (res !== 32'd14 || vcyc != 34 || bfirst != 1) begin
      n_fail++; $display("FAIL b2b_second: got %h valid %0d busy %0d want 14 34 1", res, vcyc, bfirst);
    end
  endtask

  task automatic test_reset_mid();
    int vcyc, bfirst, bcnt;
    logic [31:0] res;
    logic vafter;
    logic seen_valid;
    start_i = 1'b1; op_i = 3'b100; rs1_i = 32'hFFFF_FFF9; rs2_i = 32'd2;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 20; c++) step();
    reset_i = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: got busy %b valid %b result %h want 0 0 0", busy_o, valid_o, result_o);
    end
    step();
    step();
    reset_i = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      seen_valid |= valid_o;
      step();
    end
    n_cmp++; if (seen_valid) begin n_fail++; $display("FAIL mid_reset_valid: got 1 want 0"); end
    run_op(3'b000, 32'd3, 32'd4, vcyc, bfirst, bcnt, res, vafter);
    n_cmp++; if (res !== 32'd12 || vcyc != 2) begin
      n_fail++; $display("FAIL mid_reset_mul: got %h at cycle %0d want c at 2", res, vcyc);
    end
  endtask

  initial begin
    reset_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = 3'b000; rs1_i = 32'h0; rs2_i = 32'h0;
    step();
    step();
    test_reset();
    test_mul();
    test_special();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
